// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg: shared types, FSM encoding and lane popcount for perf_monitor_mlane
package perf_mon_pkg;
  localparam int PM_CNT_W = 32;
  localparam int PM_WIN_W = 16;
  localparam int PM_MAX_LANES = 8;
  typedef logic [PM_CNT_W-1:0] cnt_t;
  typedef logic [PM_WIN_W-1:0] win_t;
  typedef enum logic {WARMUP, RUN} pm_state_e;
  function automatic logic [3:0] popcount_lanes(input logic [PM_MAX_LANES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < PM_MAX_LANES; i++) n += 4'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: clearable accumulator (clk, rst, clr, en, add -> q, nxt); saturates when PERF_MON_SATURATE_EN is defined, else wraps
module perf_sat_counter #(
  parameter int W = 32,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [IW-1:0] add,
  output logic [W-1:0]  q,
  output logic [W-1:0]  nxt
);
`ifdef PERF_MON_SATURATE_EN
  logic [W:0] sum;
  assign sum = {1'b0, q} + (W+1)'(add);
  assign nxt = sum[W] ? '1 : sum[W-1:0];
`else
  assign nxt = q + W'(add);
`endif
  always_ff @(posedge clk) q <= (rst || clr) ? '0 : (en ? nxt : q);
endmodule

// File: rtl/perf_monitor_mlane.sv
// perf_monitor_mlane: multi-lane sample/hit/triangle/cycle monitor with snapshot handshake and windowed report; PERF_MON_SATURATE_EN selects saturating counters
module perf_monitor_mlane import perf_mon_pkg::*; #(
  parameter int SIGFIG = 24,
  parameter int VERTS = 3,
  parameter int AXIS = 3,
  parameter int LANES = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int CNT_W = $bits(cnt_t),
  parameter int WIN_W = $bits(win_t)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  input  logic [LANES-1:0]                            validSamp_R16H,
  input  logic [LANES-1:0]                            hit_valid_RnnH,
  input  logic                                        clr,
  input  logic [WIN_W-1:0]                            win_len,
  input  logic                                        snap_req,
  input  logic                                        snap_ack,
  output logic                                        snap_valid,
  output logic [CNT_W-1:0]                            snap_samples,
  output logic [CNT_W-1:0]                            snap_hits,
  output logic [CNT_W-1:0]                            snap_tris,
  output logic [CNT_W-1:0]                            snap_cycles,
  output logic                                        win_valid,
  output logic [WIN_W-1:0]                            win_samples,
  output logic [WIN_W-1:0]                            win_hits,
  output logic                                        running
);
  localparam int WC_W = $clog2(PIPE_DEPTH + 2);
  pm_state_e state, state_n;
  logic [WC_W-1:0] wcnt;
  logic [PIPE_DEPTH-1:0][LANES-1:0] vd;
  logic [PIPE_DEPTH:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] td;
  logic run, tri_chg, win_end, snap_take, win_clr;
  logic [3:0] n_samp, n_hit;
  logic [CNT_W-1:0] samples, hits, tris, cycles;
  logic [CNT_W-1:0] tot_nxt_unused [4];
  logic [WIN_W-1:0] ws, wh, ws_nxt, wh_nxt, win_cnt, wc_nxt_unused;
  always_ff @(posedge clk) begin
    state <= rst ? WARMUP : state_n;
    wcnt <= rst ? '0 : (state == WARMUP ? wcnt + WC_W'(1) : wcnt);
  end
  always_comb state_n = (state == WARMUP && wcnt == WC_W'(PIPE_DEPTH)) ? RUN : state;
  always_ff @(posedge clk) begin
    vd[0] <= validSamp_R16H;
    td[0] <= tri_R16S;
    for (int i = 1; i < PIPE_DEPTH; i++) vd[i] <= vd[i-1];
    for (int i = 1; i <= PIPE_DEPTH; i++) td[i] <= td[i-1];
  end
  assign run = state == RUN;
  assign running = run;
  assign n_samp = popcount_lanes(PM_MAX_LANES'(vd[PIPE_DEPTH-1]));
  assign n_hit = popcount_lanes(PM_MAX_LANES'(vd[PIPE_DEPTH-1] & hit_valid_RnnH));
  assign tri_chg = td[PIPE_DEPTH-1] != td[PIPE_DEPTH];
  assign win_end = run && win_len != '0 && win_cnt >= win_len - WIN_W'(1);
  assign win_clr = clr || win_end;
  assign snap_take = snap_req && (!snap_valid || snap_ack);
  perf_sat_counter #(.W(CNT_W), .IW(4)) u_samples (.clk, .rst, .clr, .en(run), .add(n_samp), .q(samples), .nxt(tot_nxt_unused[0]));
  perf_sat_counter #(.W(CNT_W), .IW(4)) u_hits (.clk, .rst, .clr, .en(run), .add(n_hit), .q(hits), .nxt(tot_nxt_unused[1]));
  perf_sat_counter #(.W(CNT_W), .IW(1)) u_tris (.clk, .rst, .clr, .en(run), .add(tri_chg), .q(tris), .nxt(tot_nxt_unused[2]));
  perf_sat_counter #(.W(CNT_W), .IW(1)) u_cycles (.clk, .rst, .clr, .en(run), .add(1'b1), .q(cycles), .nxt(tot_nxt_unused[3]));
  perf_sat_counter #(.W(WIN_W), .IW(4)) u_win_samples (.clk, .rst, .clr(win_clr), .en(run), .add(n_samp), .q(ws), .nxt(ws_nxt));
  perf_sat_counter #(.W(WIN_W), .IW(4)) u_win_hits (.clk, .rst, .clr(win_clr), .en(run), .add(n_hit), .q(wh), .nxt(wh_nxt));
  perf_sat_counter #(.W(WIN_W), .IW(1)) u_win_cnt (.clk, .rst, .clr(win_clr), .en(run), .add(1'b1), .q(win_cnt), .nxt(wc_nxt_unused));
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_valid <= 1'b0;
      {snap_samples, snap_hits, snap_tris, snap_cycles} <= '0;
      win_valid <= 1'b0;
      {win_samples, win_hits} <= '0;
    end else begin
      snap_valid <= snap_take || (snap_valid && !snap_ack);
      if (snap_take) {snap_samples, snap_hits, snap_tris, snap_cycles} <= {samples, hits, tris, cycles};
      win_valid <= win_end;
      if (win_end) {win_samples, win_hits} <= {ws_nxt, wh_nxt};
    end
  end
endmodule

// File: tb/tb_perf_monitor_mlane.sv
// tb_perf_monitor_mlane: randomized and directed checks of perf_monitor_mlane against a cycle-indexed reference model
module tb_perf_monitor_mlane;
  localparam int P = 3;
  localparam int L = 2;
`ifdef PERF_MON_SATURATE_EN
  localparam int C4_20 = 15;
`else
  localparam int C4_20 = 4;
`endif
  logic clk = 0, rst = 1, clr = 0, snap_req = 0, snap_ack = 0;
  logic signed [2:0][2:0][23:0] tri_in = '0;
  logic [L-1:0] vs = '0, hv = '0;
  logic [15:0] win_len = '0;
  logic sv, wv, run, sv4_unused, wv4_unused, run4_unused;
  logic [31:0] ss, sh, st, sc;
  logic [3:0] ss4, sh4_unused, st4_unused, sc4_unused;
  logic [15:0] ws, wh, ws4_unused, wh4_unused;
  int errors = 0, checks = 0, cyc = 0;
  logic [L-1:0] vs_h [8192];
  logic [L-1:0] hv_h [8192];
  logic [215:0] tr_h [8192];
  longint m_s, m_h, m_t, m_c, m_ws, m_wh, m_wc, e_ss, e_sh, e_st, e_sc, e_ws, e_wh;
  bit e_sv, e_wv;
  logic [215:0] pool [5];
  always #5 clk = ~clk;
  perf_monitor_mlane dut (.clk(clk), .rst(rst), .tri_R16S(tri_in), .validSamp_R16H(vs), .hit_valid_RnnH(hv),
    .clr(clr), .win_len(win_len), .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(sv),
    .snap_samples(ss), .snap_hits(sh), .snap_tris(st), .snap_cycles(sc), .win_valid(wv),
    .win_samples(ws), .win_hits(wh), .running(run));
  perf_monitor_mlane #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .tri_R16S(tri_in), .validSamp_R16H(vs), .hit_valid_RnnH(hv),
    .clr(clr), .win_len(win_len), .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(sv4_unused),
    .snap_samples(ss4), .snap_hits(sh4_unused), .snap_tris(st4_unused), .snap_cycles(sc4_unused), .win_valid(wv4_unused),
    .win_samples(ws4_unused), .win_hits(wh4_unused), .running(run4_unused));
  function automatic longint f4(longint x);
`ifdef PERF_MON_SATURATE_EN
    return x > 15 ? 15 : x;
`else
    return x % 16;
`endif
  endfunction
  task automatic do_reset();
    rst = 1; clr = 0; snap_req = 0; snap_ack = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    {m_s, m_h, m_t, m_c, m_ws, m_wh, m_wc, e_ss, e_sh, e_st, e_sc, e_ws, e_wh} = '0;
    e_sv = 0; e_wv = 0; cyc = 0;
  endtask
  task automatic tick();
    int k;
    bit r;
    longint ds, dh, dt;
    k = cyc;
    vs_h[k] = vs; hv_h[k] = hv; tr_h[k] = tri_in;
    r = k >= P + 1;
    ds = 0; dh = 0; dt = 0;
    if (r) begin
      ds = $countones(vs_h[k-P]);
      dh = $countones(vs_h[k-P] & hv);
      dt = (tr_h[k-P] != tr_h[k-P-1]) ? 1 : 0;
    end
    if (snap_req && (!e_sv || snap_ack)) begin
      e_sv = 1; e_ss = m_s; e_sh = m_h; e_st = m_t; e_sc = m_c;
    end else if (snap_ack) e_sv = 0;
    e_wv = 0;
    if (r && win_len != 0 && m_wc >= longint'(win_len) - 1) begin
      e_wv = 1; e_ws = m_ws + ds; e_wh = m_wh + dh; m_ws = 0; m_wh = 0; m_wc = 0;
    end else if (r) begin
      m_ws += ds; m_wh += dh; m_wc++;
    end
    if (r) begin m_s += ds; m_h += dh; m_t += dt; m_c++; end
    if (clr) {m_s, m_h, m_t, m_c, m_ws, m_wh, m_wc} = '0;
    @(posedge clk);
    #1 cyc++;
  endtask
  task automatic take_snap();
    snap_req = 1; snap_ack = 1;
    tick();
    snap_req = 0; snap_ack = 0;
  endtask
  task automatic test_reset();
    do_reset();
    checks += 6;
    if (sv !== 1'b0) begin errors++; $display("FAIL reset snap_valid got=%b exp=0", sv); end
    if (wv !== 1'b0) begin errors++; $display("FAIL reset win_valid got=%b exp=0", wv); end
    if (run !== 1'b0) begin errors++; $display("FAIL reset running got=%b exp=0", run); end
    if (ss !== 32'd0) begin errors++; $display("FAIL reset snap_samples got=%0d exp=0", ss); end
    if (sc !== 32'd0) begin errors++; $display("FAIL reset snap_cycles got=%0d exp=0", sc); end
    if (ws !== 16'd0) begin errors++; $display("FAIL reset win_samples got=%0d exp=0", ws); end
    repeat (P + 3) begin
      tick();
      checks++;
      if (run !== (cyc >= P + 1)) begin errors++; $display("FAIL running_rise cyc=%0d got=%b exp=%b", cyc, run, cyc >= P + 1); end
    end
  endtask
  task automatic test_full_lanes();
    do_reset();
    vs = '1; hv = '1; tri_in = pool[0];
    while (cyc < P + 11) tick();
    take_snap();
    checks += 5;
    if (sv !== 1'b1) begin errors++; $display("FAIL full snap_valid got=%b exp=1", sv); end
    if (ss !== 32'd20) begin errors++; $display("FAIL full samples got=%0d exp=20", ss); end
    if (sh !== 32'd20) begin errors++; $display("FAIL full hits got=%0d exp=20", sh); end
    if (sc !== 32'd10) begin errors++; $display("FAIL full cycles got=%0d exp=10", sc); end
    if (st !== 32'd0) begin errors++; $display("FAIL full tris got=%0d exp=0", st); end
  endtask
  task automatic test_alt_lanes();
    do_reset();
    hv = 2'b10;
    while (cyc < P + 9) begin
      vs = {cyc[0], 1'b1};
      tick();
    end
    take_snap();
    checks += 2;
    if (ss !== 32'd12) begin errors++; $display("FAIL alt samples got=%0d exp=12", ss); end
    if (sh !== 32'd4) begin errors++; $display("FAIL alt hits got=%0d exp=4", sh); end
  endtask
  task automatic test_tris();
    do_reset();
    vs = '0; hv = '0;
    while (cyc < 20 + P + 2) begin
      tri_in = pool[cyc < 20 ? cyc / 4 : 4];
      tick();
    end
    take_snap();
    checks += 2;
    if (st !== 32'd4) begin errors++; $display("FAIL tris count got=%0d exp=4", st); end
    if (st !== 32'(e_st)) begin errors++; $display("FAIL tris model got=%0d exp=%0d", st, e_st); end
    repeat (6) tick();
    take_snap();
    checks++;
    if (st !== 32'd4) begin errors++; $display("FAIL tris hold got=%0d exp=4", st); end
  endtask
  task automatic test_window();
    int pulses, late;
    do_reset();
    vs = 2'b01; hv = '0; win_len = 16'd4; pulses = 0; late = 0;
    repeat (P + 21) begin
      tick();
      checks++;
      if (wv !== e_wv) begin errors++; $display("FAIL win_valid cyc=%0d got=%b exp=%b", cyc, wv, e_wv); end
      if (wv) begin
        pulses++;
        checks += 2;
        if (ws !== 16'd4) begin errors++; $display("FAIL win_samples cyc=%0d got=%0d exp=4", cyc, ws); end
        if (wh !== 16'd0) begin errors++; $display("FAIL win_hits cyc=%0d got=%0d exp=0", cyc, wh); end
      end
    end
    checks++;
    if (pulses != 5) begin errors++; $display("FAIL win_pulse_count got=%0d exp=5", pulses); end
    win_len = '0;
    tick();
    repeat (12) begin
      tick();
      if (wv) late++;
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL win_disabled pulses got=%0d exp=0", late); end
  endtask
  task automatic test_snapshot();
    longint s0, c0;
    vs = 2'b11; hv = 2'b01;
    snap_req = 1; snap_ack = 0;
    tick();
    snap_req = 0;
    s0 = e_ss; c0 = e_sc;
    checks += 2;
    if (sv !== 1'b1) begin errors++; $display("FAIL snap first valid got=%b exp=1", sv); end
    if (ss !== 32'(s0)) begin errors++; $display("FAIL snap first samples got=%0d exp=%0d", ss, s0); end
    repeat (3) begin vs = L'($urandom); tick(); end
    snap_req = 1;
    tick();
    checks += 3;
    if (sv !== 1'b1) begin errors++; $display("FAIL snap ignored valid got=%b exp=1", sv); end
    if (ss !== 32'(s0)) begin errors++; $display("FAIL snap ignored samples got=%0d exp=%0d", ss, s0); end
    if (sc !== 32'(c0)) begin errors++; $display("FAIL snap ignored cycles got=%0d exp=%0d", sc, c0); end
    snap_ack = 1;
    tick();
    checks += 3;
    if (sv !== 1'b1) begin errors++; $display("FAIL snap reack valid got=%b exp=1", sv); end
    if (sc !== 32'(e_sc)) begin errors++; $display("FAIL snap reack cycles got=%0d exp=%0d", sc, e_sc); end
    if (ss !== 32'(e_ss)) begin errors++; $display("FAIL snap reack samples got=%0d exp=%0d", ss, e_ss); end
    snap_req = 0;
    tick();
    snap_ack = 0;
    checks++;
    if (sv !== 1'b0) begin errors++; $display("FAIL snap ack clears got=%b exp=0", sv); end
    snap_req = 1;
    tick();
    snap_req = 0;
    do_reset();
    checks += 2;
    if (sv !== 1'b0) begin errors++; $display("FAIL snap reset abort valid got=%b exp=0", sv); end
    if (ss !== 32'd0) begin errors++; $display("FAIL snap reset abort samples got=%0d exp=0", ss); end
  endtask
  task automatic test_sat_clr();
    do_reset();
    vs = 2'b11; hv = '0;
    while (cyc < P + 11) tick();
    take_snap();
    checks += 2;
    if (ss !== 32'd20) begin errors++; $display("FAIL sat samples32 got=%0d exp=20", ss); end
    if (ss4 !== 4'(C4_20)) begin errors++; $display("FAIL sat samples4 got=%0d exp=%0d", ss4, C4_20); end
    clr = 1;
    take_snap();
    clr = 0;
    checks += 3;
    if (ss !== 32'd22) begin errors++; $display("FAIL clr_snap preclear got=%0d exp=22", ss); end
    if (ss !== 32'(e_ss)) begin errors++; $display("FAIL clr_snap model got=%0d exp=%0d", ss, e_ss); end
    if (ss4 !== 4'(f4(e_ss))) begin errors++; $display("FAIL clr_snap samples4 got=%0d exp=%0d", ss4, f4(e_ss)); end
    take_snap();
    checks += 2;
    if (ss !== 32'd0) begin errors++; $display("FAIL clr totals samples got=%0d exp=0", ss); end
    if (sc !== 32'd0) begin errors++; $display("FAIL clr totals cycles got=%0d exp=0", sc); end
  endtask
  task automatic test_random();
    do_reset();
    win_len = 16'd3;
    repeat (400) begin
      vs = L'($urandom); hv = L'($urandom);
      if ($urandom_range(0, 7) == 0) tri_in = pool[$urandom_range(0, 2)];
      snap_req = $urandom_range(0, 3) == 0;
      snap_ack = $urandom_range(0, 3) == 0;
      clr = $urandom_range(0, 31) == 0;
      if ($urandom_range(0, 49) == 0) win_len = 16'($urandom_range(0, 6));
      tick();
      checks += 10;
      if (run !== (cyc >= P + 1)) begin errors++; $display("FAIL rnd running cyc=%0d got=%b", cyc, run); end
      if (wv !== e_wv) begin errors++; $display("FAIL rnd win_valid cyc=%0d got=%b exp=%b", cyc, wv, e_wv); end
      if (ws !== 16'(e_ws)) begin errors++; $display("FAIL rnd win_samples cyc=%0d got=%0d exp=%0d", cyc, ws, e_ws); end
      if (wh !== 16'(e_wh)) begin errors++; $display("FAIL rnd win_hits cyc=%0d got=%0d exp=%0d", cyc, wh, e_wh); end
      if (sv !== e_sv) begin errors++; $display("FAIL rnd snap_valid cyc=%0d got=%b exp=%b", cyc, sv, e_sv); end
      if (ss !== 32'(e_ss)) begin errors++; $display("FAIL rnd snap_samples cyc=%0d got=%0d exp=%0d", cyc, ss, e_ss); end
      if (sh !== 32'(e_sh)) begin errors++; $display("FAIL rnd snap_hits cyc=%0d got=%0d exp=%0d", cyc, sh, e_sh); end
      if (st !== 32'(e_st)) begin errors++; $display("FAIL rnd snap_tris cyc=%0d got=%0d exp=%0d", cyc, st, e_st); end
      if (sc !== 32'(e_sc)) begin errors++; $display("FAIL rnd snap_cycles cyc=%0d got=%0d exp=%0d", cyc, sc, e_sc); end
      if (ss4 !== 4'(f4(e_ss))) begin errors++; $display("FAIL rnd snap_samples4 cyc=%0d got=%0d exp=%0d", cyc, ss4, f4(e_ss)); end
    end
    clr = 0; snap_req = 0; snap_ack = 0;
  endtask
  initial begin
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 7; j++) pool[i][j*32 +: 32] = $urandom;
      pool[i][7:0] = 8'(i + 1);
    end
    tri_in = pool[0];
    test_reset();
    test_full_lanes();
    test_alt_lanes();
    test_tris();
    test_window();
    test_snapshot();
    test_sat_clr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
